spi_mem_arbiter: RTL and testbench

SPI_MEM_ARBITER -- requirements
Module: spi_mem_arbiter

---
 rtl/spi_mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_spi_mem_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_arbiter.sv
// Shares one 23LC-style SPI serial RAM (mode 0, SCK = wb_clk/2) between an ibus and a dbus requester.
// Define SPI_MEM_ARB_RR_EN for round-robin on simultaneous requests; otherwise dbus has fixed priority.
module spi_mem_arbiter #(
   parameter int AW = 24  // SPI address width, 16 or 24
) (
   input  logic        wb_clk,
   input  logic        wb_rst,
   input  logic [31:0] i_ibus_adr,
   input  logic        i_ibus_cyc,
   output logic [31:0] o_ibus_rdt,
   output logic        o_ibus_ack,
   input  logic [31:0] i_dbus_adr,
   input  logic [31:0] i_dbus_dat,
   input  logic [3:0]  i_dbus_sel,
   input  logic        i_dbus_we,
   input  logic        i_dbus_cyc,
   output logic [31:0] o_dbus_rdt,
   output logic        o_dbus_ack,
   output logic        o_spi_sck,
   output logic        o_spi_ss,
   output logic        o_spi_mosi,
   input  logic        i_spi_miso
);

   localparam int PAD = 24 - AW;

   typedef enum logic [1:0] {IDLE, SHIFT, ACK, GAP} state_t;
   state_t state, state_nxt;

   logic          pick_dbus, grant, last_bit;
   logic          sel_dbus, is_write;
   logic [6:0]    nbits;
   logic [7:0]    cnt;
   logic [63:0]   tx;
   logic [31:0]   rx;

   logic [AW-1:2] req_adr;
   logic          req_we;
   logic [1:0]    low_idx;
   logic [2:0]    pop;
   logic [31:0]   dat_shift;
   logic [31:0]   data_field;
   logic [AW-1:0] addr_field;
   logic [7:0]    cmd;
   logic [6:0]    req_nbits;
   logic [63:0]   frame;

   // Address bits outside the SPI address window are intentionally ignored.
   logic unused_adr;
   assign unused_adr = ^{i_ibus_adr[31:AW], i_ibus_adr[1:0], i_dbus_adr[31:AW], i_dbus_adr[1:0]};

`ifdef SPI_MEM_ARB_RR_EN
   logic last_dbus;  // 0 = ibus was granted last
   assign pick_dbus = i_dbus_cyc & (~i_ibus_cyc | ~last_dbus);

   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst)     last_dbus <= 1'b0;
      else if (grant) last_dbus <= pick_dbus;
   end
`else
   assign pick_dbus = i_dbus_cyc;
`endif

   // Whole frame is built left-aligned in 64 bits so the shifter always emits tx[63] first.
   always_comb begin
      req_adr = pick_dbus ? i_dbus_adr[AW-1:2] : i_ibus_adr[AW-1:2];
      req_we  = pick_dbus & i_dbus_we;
      if (i_dbus_sel[0])      low_idx = 2'd0;
      else if (i_dbus_sel[1]) low_idx = 2'd1;
      else if (i_dbus_sel[2]) low_idx = 2'd2;
      else                    low_idx = 2'd3;
      pop = {2'b00, i_dbus_sel[0]} + {2'b00, i_dbus_sel[1]}
          + {2'b00, i_dbus_sel[2]} + {2'b00, i_dbus_sel[3]};
      dat_shift  = i_dbus_dat >> {low_idx, 3'b000};
      data_field = req_we ? {dat_shift[7:0], dat_shift[15:8], dat_shift[23:16], dat_shift[31:24]}
                          : 32'h0;
      addr_field = {req_adr, req_we ? low_idx : 2'b00};
      cmd        = req_we ? 8'h02 : 8'h03;
      req_nbits  = 7'(8 + AW) + (req_we ? {1'b0, pop, 3'b000} : 7'd32);
      frame      = 64'({cmd, addr_field, data_field}) << PAD;
   end

   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      last_bit  = (cnt == {nbits, 1'b1});
      case (state)
         IDLE:    if (i_ibus_cyc || i_dbus_cyc) begin
                     grant     = 1'b1;
                     state_nxt = SHIFT;
                  end
         SHIFT:   if (last_bit) state_nxt = ACK;
         ACK:     state_nxt = GAP;
         GAP:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign o_ibus_ack = (state == ACK) & ~sel_dbus;
   assign o_dbus_ack = (state == ACK) &  sel_dbus;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         sel_dbus   <= 1'b0;
         is_write   <= 1'b0;
         nbits      <= '0;
         cnt        <= '0;
         tx         <= '0;
         rx         <= '0;
         o_spi_ss   <= 1'b1;
         o_spi_sck  <= 1'b0;
         o_spi_mosi <= 1'b0;
         o_ibus_rdt <= '0;
         o_dbus_rdt <= '0;
      end else begin
         case (state)
            IDLE: if (grant) begin
               sel_dbus   <= pick_dbus;
               is_write   <= req_we;
               nbits      <= req_nbits;
               tx         <= frame;
               cnt        <= '0;
               o_spi_ss   <= 1'b0;
               o_spi_mosi <= frame[63];
            end
            SHIFT: begin
               cnt <= cnt + 8'd1;
               if (last_bit) begin
                  o_spi_ss   <= 1'b1;
                  o_spi_sck  <= 1'b0;
                  o_spi_mosi <= 1'b0;
                  if (!is_write) begin
                     if (sel_dbus) o_dbus_rdt <= {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
                     else          o_ibus_rdt <= {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
                  end
               end else if (cnt < {nbits, 1'b0}) begin
                  // Even half-cycles raise SCK and sample MISO; odd ones lower SCK and advance MOSI.
                  if (!cnt[0]) begin
                     o_spi_sck <= 1'b1;
                     rx        <= {rx[30:0], i_spi_miso};
                  end else begin
                     o_spi_sck  <= 1'b0;
                     tx         <= tx << 1;
                     o_spi_mosi <= tx[62];
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Directed bench for spi_mem_arbiter: one AW=24 and one AW=16 instance, SPI slave model, ack scoreboard.
module tb_spi_mem_arbiter;

   typedef struct {
      int          inst;
      int          port;   // 0 = ibus, 1 = dbus
      logic [63:0] mosi;
      int          nbits;
      int          lat;
      logic [31:0] rdt;
      logic        ss;
      logic        sck;
      int          gap;
   } txn_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ibus_adr[2];
   logic        ibus_cyc[2];
   logic [31:0] ibus_rdt[2];
   logic        ibus_ack[2];
   logic [31:0] dbus_adr[2];
   logic [31:0] dbus_dat[2];
   logic [3:0]  dbus_sel[2];
   logic        dbus_we[2];
   logic        dbus_cyc[2];
   logic [31:0] dbus_rdt[2];
   logic        dbus_ack[2];
   logic        spi_sck[2];
   logic        spi_ss[2];
   logic        spi_mosi[2];
   logic        spi_miso[2];

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc_n = 0;
   logic        ss_prev[2]  = '{1'b1, 1'b1};
   logic        sck_prev[2] = '{1'b0, 1'b0};
   int          nb[2], gcyc[2], gap_cnt[2], gap_last[2];
   logic [63:0] mo[2];
   logic [31:0] miso_word[2];
   txn_t        obs_q[$];
   txn_t        exp_q[$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      spi_mem_arbiter #(.AW(g == 0 ? 24 : 16)) dut (
         .wb_clk     (clk),
         .wb_rst     (rst),
         .i_ibus_adr (ibus_adr[g]),
         .i_ibus_cyc (ibus_cyc[g]),
         .o_ibus_rdt (ibus_rdt[g]),
         .o_ibus_ack (ibus_ack[g]),
         .i_dbus_adr (dbus_adr[g]),
         .i_dbus_dat (dbus_dat[g]),
         .i_dbus_sel (dbus_sel[g]),
         .i_dbus_we  (dbus_we[g]),
         .i_dbus_cyc (dbus_cyc[g]),
         .o_dbus_rdt (dbus_rdt[g]),
         .o_dbus_ack (dbus_ack[g]),
         .o_spi_sck  (spi_sck[g]),
         .o_spi_ss   (spi_ss[g]),
         .o_spi_mosi (spi_mosi[g]),
         .i_spi_miso (spi_miso[g])
      );
   end

   always @(posedge clk) cyc_n <= cyc_n + 1;

   function automatic txn_t make_obs(int g, int port, logic [31:0] rdt);
      txn_t t;
      t.inst  = g;
      t.port  = port;
      t.mosi  = mo[g];
      t.nbits = nb[g];
      t.lat   = cyc_n - gcyc[g];
      t.rdt   = rdt;
      t.ss    = spi_ss[g];
      t.sck   = spi_sck[g];
      t.gap   = gap_last[g];
      return t;
   endfunction

   // SPI slave model and ack monitor, evaluated between active edges.
   always @(negedge clk) begin
      for (int g = 0; g < 2; g++) begin
         int hdr;
         hdr = (g == 0) ? 32 : 24;
         if (rst) begin
            nb[g]       = 0;
            mo[g]       = '0;
            gap_cnt[g]  = 0;
            spi_miso[g] = 1'b0;
         end else begin
            if (spi_ss[g]) gap_cnt[g]++;
            if (!spi_ss[g] && ss_prev[g]) begin
               gcyc[g]     = cyc_n;
               gap_last[g] = gap_cnt[g];
               gap_cnt[g]  = 0;
               nb[g]       = 0;
               mo[g]       = '0;
            end
            if (!spi_ss[g] && spi_sck[g] && !sck_prev[g]) begin
               mo[g] = {mo[g][62:0], spi_mosi[g]};
               nb[g]++;
            end
            if (!spi_ss[g] && !spi_sck[g])
               spi_miso[g] = (nb[g] >= hdr && nb[g] < hdr + 32) ? miso_word[g][31 - (nb[g] - hdr)] : 1'b0;
            if (ibus_ack[g]) obs_q.push_back(make_obs(g, 0, ibus_rdt[g]));
            if (dbus_ack[g]) obs_q.push_back(make_obs(g, 1, dbus_rdt[g]));
         end
         ss_prev[g]  = spi_ss[g];
         sck_prev[g] = spi_sck[g];
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      assert (got === want) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic expect_txn(input int inst, input int port, input logic [63:0] mosi,
                             input int nbits, input logic [31:0] rdt);
      txn_t t;
      t.inst  = inst;
      t.port  = port;
      t.mosi  = mosi;
      t.nbits = nbits;
      t.lat   = 2 * nbits + 2;
      t.rdt   = rdt;
      t.ss    = 1'b1;
      t.sck   = 1'b0;
      t.gap   = 1;
      exp_q.push_back(t);
   endtask

   // Waits (bounded) for the next ack, scores it and releases the acked requester's cyc.
   task automatic collect(input string name, output int gap);
      txn_t o, e;
      gap = 0;
      for (int i = 0; i < 600 && obs_q.size() == 0; i++) begin
         @(negedge clk);
         #1;
      end
      check({name, ".acks"}, 64'(obs_q.size()), 64'd1);
      if (obs_q.size() == 0 || exp_q.size() == 0) return;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check({name, ".inst"},    64'(o.inst),  64'(e.inst));
      check({name, ".port"},    64'(o.port),  64'(e.port));
      check({name, ".nbits"},   64'(o.nbits), 64'(e.nbits));
      check({name, ".mosi"},    o.mosi,       e.mosi);
      check({name, ".latency"}, 64'(o.lat),   64'(e.lat));
      check({name, ".rdt"},     64'(o.rdt),   64'(e.rdt));
      check({name, ".ack_ss"},  64'(o.ss),    64'(e.ss));
      check({name, ".ack_sck"}, 64'(o.sck),   64'(e.sck));
      gap = o.gap;
      if (o.port == 0) ibus_cyc[o.inst] = 1'b0;
      else             dbus_cyc[o.inst] = 1'b0;
   endtask

   task automatic ibus_req(input int inst, input logic [31:0] adr);
      ibus_adr[inst] = adr;
      ibus_cyc[inst] = 1'b1;
   endtask

   task automatic dbus_rd(input int inst, input logic [31:0] adr);
      dbus_adr[inst] = adr;
      dbus_dat[inst] = 32'h0;
      dbus_sel[inst] = 4'hF;
      dbus_we[inst]  = 1'b0;
      dbus_cyc[inst] = 1'b1;
   endtask

   task automatic dbus_wr(input int inst, input logic [31:0] adr, input logic [3:0] sel,
                          input logic [31:0] dat);
      dbus_adr[inst] = adr;
      dbus_dat[inst] = dat;
      dbus_sel[inst] = sel;
      dbus_we[inst]  = 1'b1;
      dbus_cyc[inst] = 1'b1;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int gap;
      rst = 1'b1;
      for (int g = 0; g < 2; g++) begin
         ibus_adr[g]  = '0;
         ibus_cyc[g]  = 1'b0;
         dbus_adr[g]  = '0;
         dbus_dat[g]  = '0;
         dbus_sel[g]  = 4'h0;
         dbus_we[g]   = 1'b0;
         dbus_cyc[g]  = 1'b0;
         miso_word[g] = '0;
      end
      repeat (3) @(negedge clk);
      #1;
      for (int g = 0; g < 2; g++) begin
         check("rst.ss",       64'(spi_ss[g]),   64'd1);
         check("rst.sck",      64'(spi_sck[g]),  64'd0);
         check("rst.mosi",     64'(spi_mosi[g]), 64'd0);
         check("rst.ibus_ack", 64'(ibus_ack[g]), 64'd0);
         check("rst.dbus_ack", 64'(dbus_ack[g]), 64'd0);
         check("rst.ibus_rdt", 64'(ibus_rdt[g]), 64'd0);
         check("rst.dbus_rdt", 64'(dbus_rdt[g]), 64'd0);
      end
      rst = 1'b0;
      @(negedge clk);
      #1;

      // ibus read, bytes 11 22 33 44 from the slave
      miso_word[0] = 32'h1122_3344;
      expect_txn(0, 0, {8'h03, 24'h000104, 32'h0}, 64, 32'h4433_2211);
      ibus_req(0, 32'h0000_0104);
      collect("ird", gap);

      miso_word[0] = 32'hDEAD_BEEF;
      expect_txn(0, 1, {8'h03, 24'h000208, 32'h0}, 64, 32'hEFBE_ADDE);
      dbus_rd(0, 32'h0000_020A);
      collect("drd", gap);

      // writes send only the selected bytes and leave rdt alone
      expect_txn(0, 1, {8'h02, 24'h000022, 8'hBB, 8'hAA}, 48, 32'hEFBE_ADDE);
      dbus_wr(0, 32'h0000_0020, 4'b1100, 32'hAABB_CCDD);
      collect("wr1100", gap);
      check("wr.ibus_rdt", 64'(ibus_rdt[0]), 64'h4433_2211);

      expect_txn(0, 1, {8'h02, 24'h000040, 32'h7856_3412}, 64, 32'hEFBE_ADDE);
      dbus_wr(0, 32'h0000_0040, 4'b1111, 32'h1234_5678);
      collect("wr1111", gap);

      expect_txn(0, 1, {8'h02, 24'h000044, 8'hAB}, 40, 32'hEFBE_ADDE);
      dbus_wr(0, 32'h0000_0044, 4'b0001, 32'h5A5A_5AAB);
      collect("wr0001", gap);

      expect_txn(0, 1, {8'h02, 24'h000045, 8'hDE, 8'hC0}, 48, 32'hEFBE_ADDE);
      dbus_wr(0, 32'h0000_0044, 4'b0110, 32'h11C0_DE22);
      collect("wr0110", gap);

      expect_txn(0, 1, {8'h02, 24'h00004B, 8'h99}, 40, 32'hEFBE_ADDE);
      dbus_wr(0, 32'h0000_0048, 4'b1000, 32'h9911_2233);
      collect("wr1000", gap);

      // simultaneous requests straight after reset, dbus re-requesting once
      pulse_reset();
      miso_word[0] = 32'hCAFE_F00D;
      dbus_rd(0, 32'h0000_0300);
      ibus_req(0, 32'h0000_0200);
      expect_txn(0, 1, {8'h03, 24'h000300, 32'h0}, 64, 32'h0DF0_FECA);
`ifdef SPI_MEM_ARB_RR_EN
      expect_txn(0, 0, {8'h03, 24'h000200, 32'h0}, 64, 32'h0DF0_FECA);
      expect_txn(0, 1, {8'h03, 24'h000304, 32'h0}, 64, 32'h0DF0_FECA);
`else
      expect_txn(0, 1, {8'h03, 24'h000304, 32'h0}, 64, 32'h0DF0_FECA);
      expect_txn(0, 0, {8'h03, 24'h000200, 32'h0}, 64, 32'h0DF0_FECA);
`endif
      collect("arb1", gap);
      dbus_rd(0, 32'h0000_0304);
      collect("arb2", gap);
      check("arb2.gap", 64'(gap >= 1), 64'd1);
      collect("arb3", gap);
      check("arb3.gap", 64'(gap >= 1), 64'd1);

      // reset 40 clocks into an ibus read: frame aborts, no ack, request restarts cleanly
      miso_word[0] = 32'h5566_7788;
      ibus_req(0, 32'h0000_0600);
      for (int i = 0; i < 50 && spi_ss[0]; i++) begin
         @(negedge clk);
         #1;
      end
      check("mid.started", 64'(spi_ss[0]), 64'd0);
      repeat (40) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check("mid.ss",       64'(spi_ss[0]),   64'd1);
      check("mid.sck",      64'(spi_sck[0]),  64'd0);
      check("mid.ibus_ack", 64'(ibus_ack[0]), 64'd0);
      check("mid.ibus_rdt", 64'(ibus_rdt[0]), 64'd0);
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
      check("mid.no_ack", 64'(obs_q.size()), 64'd0);
      expect_txn(0, 0, {8'h03, 24'h000600, 32'h0}, 64, 32'h8877_6655);
      collect("mid.rd", gap);

      // AW=16 instance, back-to-back dbus reads
      miso_word[1] = 32'h0102_0304;
      expect_txn(1, 1, {8'h03, 16'h1234, 32'h0}, 56, 32'h0403_0201);
      dbus_rd(1, 32'h0000_1236);
      collect("aw16.rd1", gap);
      expect_txn(1, 1, {8'h03, 16'h2000, 32'h0}, 56, 32'h0403_0201);
      dbus_rd(1, 32'h0000_2000);
      collect("aw16.rd2", gap);
      check("aw16.gap", 64'(gap >= 1), 64'd1);

      repeat (4) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
